// File: rtl/trap_sequencer.sv
// ============================================================================
// | Module   : trap_sequencer                                                |
// | Purpose  : Machine-mode CSR update sequencer for trap entry and mret.     |
// | Revision : 1.0  initial release                                          |
// ============================================================================
`default_nettype none

module trap_sequencer #(
  parameter int          XLEN        = 64,
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MTVEC   = 12'h305,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start_req,
  output logic            o_start_ack,
  input  logic            i_is_ecall,
  input  logic            i_is_mret,
  input  logic            i_is_timer_int,
  input  logic [XLEN-1:0] i_pc,
  output logic [11:0]     o_csr_addr,
  output logic            o_csr_ren,
  output logic            o_csr_wen,
  output logic [XLEN-1:0] o_csr_wdata,
  input  logic [XLEN-1:0] i_csr_rdata,
  output logic            o_done_req,
  input  logic            i_done_ack,
  output logic            o_pc_jmp,
  output logic [XLEN-1:0] o_pc_jmpaddr,
  output logic            o_busy
);

  localparam logic [XLEN-1:0] c_CAUSE_ECALL = {{(XLEN-4){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] c_CAUSE_TIMER = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_MEPC   = 3'd1,
    S_WR_MCAUSE = 3'd2,
    S_RD_MST    = 3'd3,
    S_WR_MST    = 3'd4,
    S_RD_MTVEC  = 3'd5,
    S_RD_MEPC   = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    K_NONE  = 2'd0,
    K_ECALL = 2'd1,
    K_TIMER = 2'd2,
    K_MRET  = 2'd3
  } kind_t;

  state_t          r_state;
  state_t          w_state_nxt;
  kind_t           r_kind;
  kind_t           w_kind_in;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ms;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] w_ms_trap;
  logic [XLEN-1:0] w_ms_mret;
  logic            w_accept;

  // Interrupts win over synchronous traps; mret only when nothing else is set.
  always_comb begin
    w_kind_in = K_NONE;
    if (i_is_timer_int)  w_kind_in = K_TIMER;
    else if (i_is_ecall) w_kind_in = K_ECALL;
    else if (i_is_mret)  w_kind_in = K_MRET;
  end

  assign w_accept = (r_state == S_IDLE) && i_start_req;

  // Trap entry stacks MIE into MPIE; mret restores it. MPP is always M.
  always_comb begin
    w_ms_trap        = r_ms;
    w_ms_trap[7]     = r_ms[3];
    w_ms_trap[3]     = 1'b0;
    w_ms_trap[12:11] = 2'b11;
    w_ms_mret        = r_ms;
    w_ms_mret[3]     = r_ms[7];
    w_ms_mret[7]     = 1'b1;
    w_ms_mret[12:11] = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_kind   <= K_NONE;
      r_pc     <= '0;
      r_ms     <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_kind   <= w_kind_in;
        r_pc     <= i_pc;
        r_ms     <= '0;
        r_target <= '0;
      end
      if (r_state == S_RD_MST)   r_ms     <= i_csr_rdata;
      if (r_state == S_RD_MTVEC) r_target <= {i_csr_rdata[XLEN-1:2], 2'b00};
      if (r_state == S_RD_MEPC)  r_target <= i_csr_rdata;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_start_ack  = 1'b0;
    o_busy       = 1'b1;
    o_csr_addr   = 12'h000;
    o_csr_ren    = 1'b0;
    o_csr_wen    = 1'b0;
    o_csr_wdata  = '0;
    o_done_req   = 1'b0;
    o_pc_jmp     = 1'b0;
    o_pc_jmpaddr = '0;
    case (r_state)
      S_IDLE: begin
        o_start_ack = 1'b1;
        o_busy      = 1'b0;
        if (i_start_req) begin
          case (w_kind_in)
            K_ECALL, K_TIMER: w_state_nxt = S_WR_MEPC;
            K_MRET:           w_state_nxt = S_RD_MST;
            default:          w_state_nxt = S_DONE;
          endcase
        end
      end
      S_WR_MEPC: begin
        o_csr_wen   = 1'b1;
        o_csr_addr  = CSR_MEPC;
        o_csr_wdata = r_pc;
        w_state_nxt = S_WR_MCAUSE;
      end
      S_WR_MCAUSE: begin
        o_csr_wen   = 1'b1;
        o_csr_addr  = CSR_MCAUSE;
        o_csr_wdata = (r_kind == K_TIMER) ? c_CAUSE_TIMER : c_CAUSE_ECALL;
        w_state_nxt = S_RD_MST;
      end
      S_RD_MST: begin
        o_csr_ren   = 1'b1;
        o_csr_addr  = CSR_MSTATUS;
        w_state_nxt = S_WR_MST;
      end
      S_WR_MST: begin
        o_csr_wen   = 1'b1;
        o_csr_addr  = CSR_MSTATUS;
        if (r_kind == K_MRET) begin
          o_csr_wdata = w_ms_mret;
          w_state_nxt = S_RD_MEPC;
        end else begin
          o_csr_wdata = w_ms_trap;
          w_state_nxt = S_RD_MTVEC;
        end
      end
      S_RD_MTVEC: begin
        o_csr_ren   = 1'b1;
        o_csr_addr  = CSR_MTVEC;
        w_state_nxt = S_DONE;
      end
      S_RD_MEPC: begin
        o_csr_ren   = 1'b1;
        o_csr_addr  = CSR_MEPC;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done_req   = 1'b1;
        o_pc_jmp     = (r_kind != K_NONE);
        o_pc_jmpaddr = r_target;
        if (i_done_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// ============================================================================
// | Module   : tb_trap_sequencer                                             |
// | Purpose  : Directed and randomized self-checking bench for trap_sequencer.|
// | Revision : 1.0  initial release                                          |
// ============================================================================
`default_nettype none

module tb_trap_sequencer;

  localparam logic [11:0] c_A_MST    = 12'h300;
  localparam logic [11:0] c_A_MTVEC  = 12'h305;
  localparam logic [11:0] c_A_MEPC   = 12'h341;
  localparam logic [11:0] c_A_MCAUSE = 12'h342;

  typedef struct packed {
    logic        w;
    logic [11:0] a;
    logic [63:0] d;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start_req = 1'b0;
  logic        i_is_ecall = 1'b0;
  logic        i_is_mret = 1'b0;
  logic        i_is_timer_int = 1'b0;
  logic [63:0] i_pc = '0;
  logic        i_done_ack = 1'b0;
  logic [63:0] csr_rdata;
  logic        o_start_ack, o_csr_ren, o_csr_wen, o_done_req, o_pc_jmp, o_busy;
  logic [11:0] o_csr_addr;
  logic [63:0] o_csr_wdata, o_pc_jmpaddr;

  logic [63:0] m_mstatus = '0, m_mtvec = '0, m_mepc = '0, m_mcause = '0;
  acc_t        log_q[$];
  acc_t        exp_q[$];
  int          n_pass = 0, n_fail = 0, n_total = 0;

  trap_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start_req   (i_start_req),
    .o_start_ack   (o_start_ack),
    .i_is_ecall    (i_is_ecall),
    .i_is_mret     (i_is_mret),
    .i_is_timer_int(i_is_timer_int),
    .i_pc          (i_pc),
    .o_csr_addr    (o_csr_addr),
    .o_csr_ren     (o_csr_ren),
    .o_csr_wen     (o_csr_wen),
    .o_csr_wdata   (o_csr_wdata),
    .i_csr_rdata   (csr_rdata),
    .o_done_req    (o_done_req),
    .i_done_ack    (i_done_ack),
    .o_pc_jmp      (o_pc_jmp),
    .o_pc_jmpaddr  (o_pc_jmpaddr),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  // CSR file model: combinational read, garbage when not reading.
  always_comb begin
    csr_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    if (o_csr_ren) begin
      case (o_csr_addr)
        c_A_MST:    csr_rdata = m_mstatus;
        c_A_MTVEC:  csr_rdata = m_mtvec;
        c_A_MEPC:   csr_rdata = m_mepc;
        c_A_MCAUSE: csr_rdata = m_mcause;
        default:    csr_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic acc_t mk(input logic w, input logic [11:0] a, input logic [63:0] d);
    acc_t e;
    e.w = w; e.a = a; e.d = d;
    return e;
  endfunction

  function automatic logic [63:0] trap_ms(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1800 | (m[3] ? 64'h80 : 64'h0);
  endfunction

  function automatic logic [63:0] mret_ms(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1880 | (m[7] ? 64'h8 : 64'h0);
  endfunction

  // One clock: observe the CSR port mid-cycle, then land 1 time unit past the next edge.
  task automatic step();
    @(negedge clk);
    if (rst_n) begin
      chk("csr_ren_wen_excl", o_csr_ren & o_csr_wen, 0);
      if (!o_busy || o_done_req)
        chk("csr_quiet", |{o_csr_addr, o_csr_ren, o_csr_wen, o_csr_wdata}, 0);
      if (o_csr_wen) begin
        log_q.push_back(mk(1'b1, o_csr_addr, o_csr_wdata));
        case (o_csr_addr)
          c_A_MST:    m_mstatus = o_csr_wdata;
          c_A_MTVEC:  m_mtvec   = o_csr_wdata;
          c_A_MEPC:   m_mepc    = o_csr_wdata;
          c_A_MCAUSE: m_mcause  = o_csr_wdata;
          default: ;
        endcase
      end else if (o_csr_ren) begin
        log_q.push_back(mk(1'b0, o_csr_addr, 64'd0));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input logic ec, input logic mr, input logic ti, input logic [63:0] pc,
                         input int hold, input logic keep_req, input string tag);
    int          lat_exp;
    int          n;
    logic        jmp_exp;
    logic [63:0] tgt_exp;
    exp_q.delete();
    log_q.delete();
    if (ti || ec) begin
      exp_q.push_back(mk(1'b1, c_A_MEPC, pc));
      exp_q.push_back(mk(1'b1, c_A_MCAUSE, ti ? 64'h8000_0000_0000_0007 : 64'd11));
      exp_q.push_back(mk(1'b0, c_A_MST, 64'd0));
      exp_q.push_back(mk(1'b1, c_A_MST, trap_ms(m_mstatus)));
      exp_q.push_back(mk(1'b0, c_A_MTVEC, 64'd0));
      lat_exp = 6; jmp_exp = 1'b1; tgt_exp = m_mtvec & ~64'h3;
    end else if (mr) begin
      exp_q.push_back(mk(1'b0, c_A_MST, 64'd0));
      exp_q.push_back(mk(1'b1, c_A_MST, mret_ms(m_mstatus)));
      exp_q.push_back(mk(1'b0, c_A_MEPC, 64'd0));
      lat_exp = 4; jmp_exp = 1'b1; tgt_exp = m_mepc;
    end else begin
      lat_exp = 1; jmp_exp = 1'b0; tgt_exp = 64'd0;
    end

    chk({tag, "_start_ack_idle"}, {o_start_ack, o_busy}, 2'b10);
    i_start_req = 1'b1;
    i_is_ecall = ec; i_is_mret = mr; i_is_timer_int = ti; i_pc = pc;
    step();
    n = 1;
    if (!keep_req) i_start_req = 1'b0;
    {i_is_timer_int, i_is_ecall, i_is_mret} = 3'($urandom);
    i_pc = {$urandom, $urandom};
    while (!o_done_req && n < 12) begin
      chk({tag, "_busy_no_ack"}, {o_busy, o_start_ack}, 2'b10);
      i_done_ack = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    i_done_ack = 1'b0;
    chk({tag, "_latency"}, n, lat_exp);
    chk({tag, "_done"}, {o_done_req, o_pc_jmp, o_pc_jmpaddr}, {1'b1, jmp_exp, tgt_exp});
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold"}, {o_done_req, o_pc_jmp, o_pc_jmpaddr, o_busy}, {1'b1, jmp_exp, tgt_exp, 1'b1});
    end
    i_done_ack = 1'b1;
    {i_is_timer_int, i_is_ecall, i_is_mret} = 3'b000;
    step();
    i_done_ack = 1'b0;
    chk({tag, "_after_ack"}, {o_start_ack, o_busy, o_done_req, o_pc_jmp, o_pc_jmpaddr},
        {1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
    chk({tag, "_log_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk({tag, "_log_entry"}, log_q[i], exp_q[i]);
  endtask

  initial begin
    logic [63:0] pc;
    logic        saw_mst_wr;
    #3;
    chk("reset_state", {o_start_ack, o_busy, o_done_req, o_pc_jmp, o_csr_ren, o_csr_wen},
        6'b100000);
    chk("reset_buses", |{o_csr_addr, o_csr_wdata, o_pc_jmpaddr}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // T1 ecall
    m_mstatus = 64'h8; m_mtvec = 64'h8000_1001;
    run_seq(1'b1, 1'b0, 1'b0, 64'h8000_0010, 0, 1'b0, "T1");
    chk("T1_mepc", m_mepc, 64'h8000_0010);
    chk("T1_mcause", m_mcause, 64'd11);
    chk("T1_mstatus", m_mstatus, 64'h1880);

    // T2 mret
    m_mstatus = 64'h1880; m_mepc = 64'h8000_0014;
    run_seq(1'b0, 1'b1, 1'b0, 64'h1234, 0, 1'b0, "T2");
    chk("T2_mstatus", m_mstatus, 64'h1888);

    // T3 timer and ecall together
    run_seq(1'b1, 1'b0, 1'b1, 64'h0000_0040_0000_1230, 0, 1'b0, "T3");
    chk("T3_mcause", m_mcause, 64'h8000_0000_0000_0007);
    chk("T3_mepc", m_mepc, 64'h0000_0040_0000_1230);

    // T4 ack withheld for three cycles
    run_seq(1'b1, 1'b0, 1'b0, 64'h8000_0100, 3, 1'b0, "T4");

    // T5 reset during the mstatus write
    m_mstatus = 64'h8;
    log_q.delete();
    i_start_req = 1'b1; i_is_ecall = 1'b1; i_pc = 64'h8000_0200;
    step();
    i_start_req = 1'b0; i_is_ecall = 1'b0;
    repeat (3) step();
    chk("T5_in_wr_mst", {o_csr_wen, o_csr_addr}, {1'b1, c_A_MST});
    #1 rst_n = 1'b0;
    #1;
    chk("T5_reset_ctrl", {o_start_ack, o_busy, o_done_req, o_pc_jmp, o_csr_ren, o_csr_wen},
        6'b100000);
    chk("T5_reset_buses", |{o_csr_addr, o_csr_wdata, o_pc_jmpaddr}, 0);
    step();
    rst_n = 1'b1;
    step();
    saw_mst_wr = 1'b0;
    foreach (log_q[i]) if (log_q[i].w && log_q[i].a == c_A_MST) saw_mst_wr = 1'b1;
    chk("T5_no_mst_write", {saw_mst_wr, m_mstatus}, {1'b0, 64'h8});
    chk("T5_idle", {o_start_ack, o_busy}, 2'b10);

    // T6 start_req held high, then a kind-less request on the first idle cycle
    run_seq(1'b1, 1'b0, 1'b0, 64'h8000_0300, 1, 1'b1, "T6a");
    run_seq(1'b0, 1'b0, 1'b0, 64'h8000_0400, 0, 1'b0, "T6b");

    // Randomized sequences against the reference model
    for (int r = 0; r < 24; r++) begin
      logic [2:0] k;
      m_mstatus = {$urandom, $urandom};
      m_mtvec   = {$urandom, $urandom};
      m_mepc    = {$urandom, $urandom};
      k  = 3'($urandom_range(0, 7));
      pc = {$urandom, $urandom};
      run_seq(k[0], k[1], k[2], pc, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "RND");
      i_start_req = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
